// File: rtl/pkd_ser_pkg.sv
// Shared types and constants for the packed element serializer and its
// downstream deserializer partner.
package pkd_ser_pkg;

    localparam int unsigned D0     = 3;
    localparam int unsigned D1     = 2;
    localparam int unsigned D2     = 3;
    localparam int unsigned ELEM_W = 3;
    localparam int unsigned N_ELEM = D0 * D1 * D2;
    localparam int unsigned IDX_W  = $clog2(N_ELEM);
    localparam int unsigned WORD_W = N_ELEM * ELEM_W;

    typedef logic [ELEM_W-1:0] elem_t;
    typedef logic [D0-1:0][D1-1:0][D2-1:0][ELEM_W-1:0] pword_t;

    typedef enum logic [0:0] {
        IDLE,
        SEND
    } state_t;

    // Leftmost (most significant) element of a packed word.
    function automatic elem_t head_elem(input pword_t w);
        return w[D0-1][D1-1][D2-1];
    endfunction

    // Drop the leftmost element and pull zeros in at the right.
    function automatic pword_t shift_out(input pword_t w);
        logic [WORD_W-1:0] flat;
        flat = w;
        return flat << ELEM_W;
    endfunction

endpackage

// File: rtl/pkd_idx_counter.sv
// Modulo-N element index counter. clr has priority over inc; wrap pulses in
// the cycle an increment takes the count from N-1 back to 0.
module pkd_idx_counter #(
    parameter int unsigned N = 18,
    parameter int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] MAX = W'(N - 1);

    logic [W-1:0] count_q;
    logic         at_max;

    assign at_max = (count_q == MAX);
    assign wrap   = inc && !clr && at_max;
    assign count  = count_q;

    // Count with synchronous reset; clear wins over increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= at_max ? '0 : count_q + W'(1);
        end
    end

    a_count_in_range: assert property (@(posedge clk) disable iff (!rst_n) count_q <= MAX)
        else $error("index counter out of range");

endmodule

// File: rtl/packed_elem_serializer.sv
// Packed word to element stream serializer.
// Takes one N_ELEM*ELEM_W word on the in_* handshake and emits its elements,
// leftmost (MSB) first, on the out_* handshake with index and last flag.
// Optional: define PKD_PARITY_EN to add out_par, the even parity of out_data.
module packed_elem_serializer
    import pkd_ser_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ELEM_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    input  logic              flush
`ifdef PKD_PARITY_EN
    ,
    output logic              out_par
`endif
);

    state_t           state_q;
    pword_t           shreg_q;
    pword_t           shreg_d;
    logic [IDX_W-1:0] idx;
    logic             idx_wrap;
    logic             sending;
    logic             at_last;
    logic             xfer;
    logic             last_xfer;
    logic             load;
    logic             idx_clr;

    assign sending   = (state_q == SEND);
    assign at_last   = (idx == IDX_W'(N_ELEM - 1));
    // Flush wins over the output handshake: the element is not transferred.
    assign xfer      = sending && out_ready && !flush;
    assign last_xfer = xfer && at_last;
    // Ready in IDLE, and also while the last element leaves, so words can
    // follow each other without a bubble. Flush always blocks a load.
    assign in_ready  = !flush && (!sending || last_xfer);
    assign load      = in_valid && in_ready;
    assign idx_clr   = load || (sending && flush);

    assign out_valid = sending;
    assign out_data  = head_elem(shreg_q);
    assign out_idx   = idx;
    assign out_last  = sending && at_last;

    pkd_idx_counter #(
        .N (N_ELEM),
        .W (IDX_W)
    ) u_idx_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (xfer),
        .clr   (idx_clr),
        .count (idx),
        .wrap  (idx_wrap)
    );

    // Next shift register contents: load, clear on flush, or shift on transfer.
    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = in_data;
        end else if (sending && flush) begin
            shreg_d = '0;
        end else if (xfer) begin
            shreg_d = shift_out(shreg_q);
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
            unique case (state_q)
                IDLE: begin
                    if (load) begin
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else if (last_xfer && !load) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef PKD_PARITY_EN
    logic par_q;

    // Parity of the element that will be on out_data next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= ^head_elem(shreg_d);
        end
    end

    assign out_par = par_q;
`endif

    a_wrap_only_on_last: assert property (@(posedge clk) disable iff (!rst_n)
        idx_wrap |-> out_last)
        else $error("index wrapped without out_last");

    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready && !flush) |=>
            (out_valid && $stable(out_data) && $stable(out_idx)))
        else $error("output changed while stalled");

endmodule

// File: tb/tb_packed_elem_serializer.sv
module tb_packed_elem_serializer;
    import pkd_ser_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [ELEM_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
    logic              flush;
`ifdef PKD_PARITY_EN
    logic              out_par;
`endif

    packed_elem_serializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .flush     (flush)
`ifdef PKD_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit mdl_on   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Element k of a word, counted from the most significant end.
    function automatic logic [2:0] ref_elem(input logic [53:0] w, input int k);
        logic [53:0] s;
        s = w >> (3 * (17 - k));
        return s[2:0];
    endfunction

    // Reference model: the elements still owed to the consumer, front first.
    logic [2:0] q[$];

    always @(negedge clk) begin
        if (mdl_on) begin
            bit exp_valid;
            bit exp_rdy;
            exp_valid = (q.size() != 0);
            exp_rdy   = !flush && (q.size() == 0 || (q.size() == 1 && out_ready));
            check("m_in_ready", in_ready, exp_rdy);
            check("m_out_valid", out_valid, exp_valid);
            if (exp_valid) begin
                check("m_out_data", out_data, q[0]);
                check("m_out_idx", out_idx, 18 - q.size());
                check("m_out_last", out_last, q.size() == 1);
`ifdef PKD_PARITY_EN
                check("m_out_par", out_par, ^q[0]);
`endif
            end else begin
                check("m_out_last_idle", out_last, 0);
            end
            if (!rst_n) begin
                q.delete();
            end else begin
                if (flush) q.delete();
                else if (exp_valid && out_ready) void'(q.pop_front());
                if (in_valid && exp_rdy)
                    for (int k = 0; k < 18; k++) q.push_back(ref_elem(in_data, k));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [53:0] w);
        bit got;
        got = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
            tick();
        end
        in_valid = 1'b0;
        check("load_accepted", got, 1);
    endtask

    typedef struct {
        logic [53:0] word;
        int          k;
        logic [2:0]  data;
        logic        last;
    } vec_t;

    localparam logic [53:0] WA   = 54'h2_AAAA_5555_1234;
    localparam logic [53:0] WB   = 54'h3_8E1C_7F00_AB12;
    localparam logic [53:0] ONES = {54{1'b1}};

    vec_t vec[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{WA, 0, 3'd0, 1'b0};
        vec[1] = '{WA, 7, 3'd1, 1'b0};
        vec[2] = '{WA, 12, 3'd2, 1'b0};
        vec[3] = '{WA, 16, 3'd6, 1'b0};
        vec[4] = '{WA, 17, 3'd4, 1'b1};
        vec[5] = '{ONES, 0, 3'd7, 1'b0};
        vec[6] = '{ONES, 17, 3'd7, 1'b1};
        vec[7] = '{54'h1, 16, 3'd0, 1'b0};
        vec[8] = '{54'h1, 17, 3'd1, 1'b1};
        vec[9] = '{54'h20_0000_0000_0000, 0, 3'd4, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
        repeat (2) tick();
        mdl_on = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_last", out_last, 0);
`ifdef PKD_PARITY_EN
        check("rst_out_par", out_par, 0);
`endif
        tick();
        rst_n = 1'b1;

        // Table: load a word, stream k elements, inspect element k, then flush.
        foreach (vec[i]) begin
            out_ready = 1'b0;
            load_word(vec[i].word);
            out_ready = 1'b1;
            repeat (vec[i].k) tick();
            @(negedge clk);
            check("vec_valid", out_valid, 1);
            check("vec_data", out_data, vec[i].data);
            check("vec_idx", out_idx, vec[i].k);
            check("vec_last", out_last, vec[i].last);
            tick();
            out_ready = 1'b0; flush = 1'b1;
            tick();
            flush = 1'b0;
        end

        // Full word at full rate: last on the 18th cycle, then idle.
        begin
            int last_at;
            last_at = -1;
            out_ready = 1'b1;
            load_word(WA);
            for (int i = 0; i < 40 && last_at < 0; i++) begin
                @(negedge clk);
                if (out_valid && out_last) last_at = i;
                tick();
            end
            check("order_last_cycle", last_at, 17);
            @(negedge clk);
            check("order_idle_after", out_valid, 0);
            tick();
        end

        // Backpressure with out_ready pattern 1,0,0,1.
        begin
            logic [3:0]        pat;
            int                delivered;
            bit                done;
            bit                stalled;
            logic [ELEM_W-1:0] pd;
            logic [IDX_W-1:0]  pi;
            pat = 4'b1001; delivered = 0; done = 1'b0; stalled = 1'b0;
            pd = '0; pi = '0;
            out_ready = 1'b0;
            load_word(WA);
            for (int c = 0; c < 100 && !done; c++) begin
                out_ready = pat[c % 4];
                @(negedge clk);
                if (stalled) begin
                    check("bp_hold_data", out_data, pd);
                    check("bp_hold_idx", out_idx, pi);
                end
                stalled = out_valid && !out_ready;
                pd = out_data; pi = out_idx;
                if (out_valid && out_ready) begin
                    delivered++;
                    if (out_last) done = 1'b1;
                end
                tick();
            end
            check("bp_delivered", delivered, 18);
            check("bp_done", done, 1);
        end

        // Back-to-back: next word offered while the last element leaves.
        out_ready = 1'b1;
        load_word(WA);
        repeat (17) tick();
        in_valid = 1'b1; in_data = WB;
        @(negedge clk);
        check("b2b_in_ready", in_ready, 1);
        check("b2b_a_last", out_last, 1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_valid", out_valid, 1);
        check("b2b_idx", out_idx, 0);
        check("b2b_data", out_data, ref_elem(WB, 0));
        tick();
        repeat (17) tick();
        @(negedge clk);
        check("b2b_idle_after", out_valid, 0);
        tick();

        // Flush at idx 5 together with out_ready.
        out_ready = 1'b1;
        load_word(WA);
        repeat (5) tick();
        flush = 1'b1;
        @(negedge clk);
        check("fl_idx_before", out_idx, 5);
        tick();
        flush = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("fl_valid", out_valid, 0);
        check("fl_idx", out_idx, 0);
        tick();
        load_word(WB);
        @(negedge clk);
        check("fl_restart_idx", out_idx, 0);
        check("fl_restart_data", out_data, ref_elem(WB, 0));
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        // Flush in IDLE blocks a load.
        in_valid = 1'b1; in_data = WA; flush = 1'b1;
        @(negedge clk);
        check("fl_idle_block", in_ready, 0);
        tick();
        in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("fl_idle_noload", out_valid, 0);
        tick();

        // Reset mid-word at idx 7.
        out_ready = 1'b1;
        load_word(WA);
        repeat (7) tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("rm_idx_before", out_idx, 7);
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rm_in_ready", in_ready, 1);
        check("rm_valid", out_valid, 0);
        check("rm_idx", out_idx, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rm_quiet", out_valid, 0);
            tick();
        end

`ifdef PKD_PARITY_EN
        out_ready = 1'b1;
        load_word(ONES);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            check("par_ones", out_par, 1);
            tick();
        end
        load_word('0);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            check("par_zeros", out_par, 0);
            tick();
        end
`endif

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            logic [63:0] r;
            r = {$urandom(), $urandom()};
            rst_n     = ($urandom_range(0, 299) != 0);
            in_valid  = ($urandom_range(0, 1) == 1);
            in_data   = r[53:0];
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 39) == 0);
            tick();
        end

        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
